// File: rtl/seq_1010_generator.sv
// Serial "1010" pattern source: sends N non-overlapping 1010 patterns separated
// by a programmable run of idle zeros, with Moore-registered framing outputs.
module seq_1010_generator #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             ready,
  output logic             out,
  output logic             valid,
  output logic             last_bit,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_B1   = 3'd1;
  localparam logic [2:0] S_B2   = 3'd2;
  localparam logic [2:0] S_B3   = 3'd3;
  localparam logic [2:0] S_B4   = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_pat_cnt;
  logic             r_ready, r_out, r_valid, r_last, r_done;

  logic [2:0]       w_next;
  logic             w_accept;
  logic             w_pat_inc;
  logic [CNT_W-1:0] w_pat_nxt;

  assign w_accept  = (r_state == S_IDLE) && start && (count != '0);
  assign w_pat_nxt = r_pat_cnt + 1'b1;

  always_comb begin
    w_next    = r_state;
    w_pat_inc = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_B1;
      S_B1:   w_next = S_B2;
      S_B2:   w_next = S_B3;
      S_B3:   w_next = S_B4;
      S_B4: begin
        w_pat_inc = 1'b1;
        if (w_pat_nxt == r_count) w_next = S_DONE;
        else if (r_gap != '0)     w_next = S_GAP;
        else                      w_next = S_B1;
      end
      S_GAP:  if (r_gap_cnt == '0) w_next = S_B1;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort wins over everything mid-frame, including the B4 count update.
    if (abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
      w_next    = S_IDLE;
      w_pat_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_pat_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_count   <= count;
        r_gap     <= gap;
        r_pat_cnt <= '0;
      end else if (w_pat_inc) begin
        r_pat_cnt <= w_pat_nxt;
      end
      // GAP runs for r_gap cycles: load gap-1 on entry, leave when it hits 0.
      if (r_state == S_B4 && w_next == S_GAP) r_gap_cnt <= r_gap - 1'b1;
      else if (r_state == S_GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b1;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_out   <= (w_next == S_B1) || (w_next == S_B3);
      r_valid <= (w_next == S_B1) || (w_next == S_B2) ||
                 (w_next == S_B3) || (w_next == S_B4);
      r_last  <= (w_next == S_B4);
      r_done  <= (w_next == S_DONE);
    end
  end

  assign ready    = r_ready;
  assign out      = r_out;
  assign valid    = r_valid;
  assign last_bit = r_last;
  assign done     = r_done;
  assign pat_cnt  = r_pat_cnt;

endmodule

// File: doc/seq_1010_generator.md
# seq_1010_generator

Serial pattern source for the 1010 sequence-detector family: on a start request it transmits N non-overlapping "1010" patterns on a single-bit serial line, separated by a programmable number of idle zero bits. It drives the `in` port of the non-overlapping 1010 detector (same `clk`) and provides a known-good stimulus and loopback source for it. All outputs are registered (Moore style). Frame framing is reported through `valid`, `last_bit`, `done` and a pattern counter.

## Interface
Parameters:
- CNT_W, 8, width of pattern-count request and `pat_cnt`
- GAP_W, 4, width of inter-pattern gap length

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  frame request, sampled only when `ready`=1
- count  input  CNT_W  number of 1010 patterns to send; latched on accept
- gap  input  GAP_W  zero bits between patterns; latched on accept
- abort  input  1  synchronous frame cancel
- ready  output  1  1 = idle, able to accept `start`
- out  output  1  serial bit stream
- valid  output  1  1 while `out` carries a pattern bit (not gap or idle)
- last_bit  output  1  1 during the final (fourth) bit of each pattern
- done  output  1  one-cycle pulse after the final pattern of a frame
- pat_cnt  output  CNT_W  patterns completed in the current or last frame

## Operation
- States: IDLE, B1 (out=1), B2 (out=0), B3 (out=1), B4 (out=0, last_bit=1), GAP (out=0, valid=0), DONE (done=1).
- valid=1 in B1–B4 only; ready=1 in IDLE only; out=0 in IDLE, GAP and DONE.
- Accept: IDLE with start=1 and count!=0. Latch count and gap, clear pat_cnt, go to B1. start with count=0 is ignored; the block stays in IDLE and done does not pulse.
- B1→B2→B3→B4 unconditionally, one cycle each.
- Leaving B4: pat_cnt increments. If the incremented value equals the latched count, go to DONE. Otherwise go to GAP when the latched gap is nonzero, or straight to B1 when gap=0 (back-to-back 10101010...).
- GAP lasts exactly the latched gap cycles (internal down-counter), then goes to B1.
- DONE lasts one cycle, then goes to IDLE. pat_cnt holds its value until the next accept.
- abort=1 in any state other than IDLE or DONE: go to IDLE at the next edge. done does not pulse, pat_cnt holds its value, and a partial pattern is truncated. abort in IDLE or DONE has no effect.
- start while not in IDLE is ignored. Changes to count or gap mid-frame are ignored.
- Reset (rst=0, any time, including mid-frame): immediately IDLE, out=0, valid=0, last_bit=0, done=0, ready=1, pat_cnt=0, latched count/gap=0, gap counter=0.

## Timing
- Start accepted at edge E0 → first bit (out=1, valid=1) visible in the cycle after E0.
- Frame length from E0: 4N + gap·(N−1) active cycles, then one DONE cycle, then ready=1.
- last_bit is high in cycles 4, 8+gap, …, counted from the first bit.
- With gap=0, patterns run contiguously with no idle bit between them.
- Max count = 2^CNT_W−1. pat_cnt never wraps within a frame.

## Test plan
- Reset: hold rst=0 with random inputs → out=0, valid=0, ready=1, done=0, pat_cnt=0. Release, idle 3 cycles → outputs unchanged.
- count=1, gap=0: out=1,0,1,0 in cycles 1–4 after accept, last_bit in cycle 4, done in cycle 5, ready in cycle 6, pat_cnt=1. Detector on `out` fires once.
- count=3, gap=2: out=1010 00 1010 00 1010 (16 cycles), valid low during the 4 gap cycles, done in cycle 17, pat_cnt=3. Detector fires 3 times.
- count=2, gap=0: out=10101010 contiguous, done in cycle 9, pat_cnt=2. Non-overlapping detector fires twice.
- count=0 with start=1 → ready stays 1, no valid bits, no done. Then start with count=1 while busy → second start ignored, exactly one pattern sent.
- count=4, gap=1: assert abort during the second B3 → IDLE next cycle, no done, pat_cnt=1. Repeat the frame and pull rst low mid-GAP → all outputs return to reset values immediately.
